uart_packet_arbiter: RTL and testbench
======================================

UART_PACKET_ARBITER -- requirements
Module: uart_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 4: number of AXI-4 stream byte sources, 2..8.
REQ-002 SHALL have parameter MAX_PACKET_LENGTH_BYTES, default 16: maximum beats per granted packet.
REQ-003 SHALL have parameter WATCHDOG_CYCLES, default 1024: stall limit, used only when the watchdog is compiled in.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_s_axis_tvalid, input, NUM_REQUESTERS bits: per-source tvalid.
REQ-007 SHALL have port o_s_axis_tready, output, NUM_REQUESTERS bits: per-source tready.
REQ-008 SHALL have port i_s_axis_tdata, input, NUM_REQUESTERS x 8 bits: per-source data byte.
REQ-009 SHALL have port i_s_axis_tlast, input, NUM_REQUESTERS bits: per-source end of packet.
REQ-010 SHALL have port o_m_axis_tvalid, input/output pair with i_m_axis_tready, 1 bit each: master handshake toward the shared UART packet transmitter.
REQ-011 SHALL have port o_m_axis_tdata, output, 8 bits, and port o_m_axis_tlast, output, 1 bit.
REQ-012 SHALL have port o_grant, output, NUM_REQUESTERS bits: one-hot current owner, all-zero when idle.
REQ-013 SHALL have port o_overlength, output, 1 bit: one-cycle pulse when a packet is truncated.
REQ-014 SHALL have port o_watchdog_abort, output, 1 bit: one-cycle pulse on a watchdog abort.

Function
REQ-015 SHALL implement states IDLE, PASS and ABORT; ABORT SHALL exist only when the watchdog is compiled in.
REQ-016 In IDLE with any tvalid high, SHALL select the first requesting source in round-robin order starting at last_grant+1 (modulo NUM_REQUESTERS), register o_grant, and enter PASS on the next edge.
- Arbitration latency: 1 cycle.
- In IDLE, all tready and o_m_axis_tvalid SHALL be 0.
REQ-017 In PASS, the granted source SHALL connect combinationally to the master:
- m_tvalid = s_tvalid[g]; m_tdata = s_tdata[g]; s_tready[g] = m_tready.
- Every other source's tready SHALL be 0.
REQ-018 A beat SHALL count only when m_tvalid and m_tready are both high; the 8-bit beat counter SHALL reset to 0 on each new grant.
REQ-019 o_m_axis_tlast SHALL be s_tlast[g] OR (beat counter == MAX_PACKET_LENGTH_BYTES-1).
REQ-020 A forced-tlast beat with s_tlast[g]=0 SHALL pulse o_overlength the cycle after its handshake.
- The source keeps its remaining bytes.
- Those bytes compete as a new packet.
REQ-021 A handshake with o_m_axis_tlast high SHALL return the block to IDLE and update last_grant to g.
- Exactly one idle cycle between packets.
REQ-022 The granted source dropping tvalid mid-packet SHALL NOT release the grant; tvalid changes on ungranted sources SHALL NOT affect the current packet.
REQ-023 Master signals SHALL never change while m_tvalid=1 and m_tready=0, provided the source obeys AXI-S.

Reset
REQ-024 Reset SHALL force state IDLE, o_grant=0, last_grant=NUM_REQUESTERS-1 (source 0 first), beat counter 0, watchdog counter 0.
REQ-025 Reset SHALL drive all tready, o_m_axis_tvalid, o_m_axis_tlast, o_overlength and o_watchdog_abort to 0, and o_m_axis_tdata to 0x00.
REQ-026 Reset asserted mid-packet SHALL abandon the packet immediately with no tlast emitted.

Configuration
REQ-027 Macro UART_PACKET_ARB_WATCHDOG_EN SHALL enable the watchdog; the port list SHALL be identical with and without it.
REQ-028 With the macro, a stall counter in PASS SHALL count consecutive cycles with s_tvalid[g]=0 and clear on any tvalid-high cycle.
- At WATCHDOG_CYCLES, the block SHALL enter ABORT.
- In ABORT: m_tvalid=1, m_tdata=0x00, m_tlast=1, all s_tready=0.
- On the handshake, it SHALL go to IDLE, update last_grant, and pulse o_watchdog_abort.
REQ-029 Without the macro, a stalled source SHALL hold the grant indefinitely and o_watchdog_abort SHALL be tied 0.

Verification
REQ-030 Sources 0 and 2 each present a 3-byte packet in the same cycle -> source 0's bytes, one idle cycle, then source 2's; tlast on the 3rd byte of each.
REQ-031 All 4 sources continuously request 1-byte packets -> grant order 0,1,2,3,0; no source is granted twice in a row while others wait.
REQ-032 Source 1 sends 20 bytes, tlast on byte 20, MAX=16 -> byte 16 carries forced tlast and o_overlength pulses; bytes 17-20 follow as a second packet.
REQ-033 m_tready toggles 1,0,0,1 during a 4-byte packet -> output stable while stalled; all 4 bytes delivered in order.
REQ-034 With the macro and WATCHDOG_CYCLES=8, source 3 stalls after 2 bytes -> after 8 idle cycles one 0x00 beat with tlast, o_watchdog_abort pulses, state IDLE.
REQ-035 i_rst_n asserted on the 2nd beat of a packet -> all outputs 0 immediately; after release, source 0 wins the first arbitration.

Source files
------------

// File: rtl/uart_packet_arbiter.sv
// Round-robin arbiter merging AXI-S byte packets onto one UART transmitter.
// Define UART_PACKET_ARB_WATCHDOG_EN to build in the stalled-source watchdog.
module uart_packet_arbiter #(
  parameter int NUM_REQUESTERS          = 4,
  parameter int MAX_PACKET_LENGTH_BYTES = 16,
  parameter int WATCHDOG_CYCLES         = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQUESTERS-1:0]      i_s_axis_tvalid,
  output logic [NUM_REQUESTERS-1:0]      o_s_axis_tready,
  input  logic [NUM_REQUESTERS-1:0][7:0] i_s_axis_tdata,
  input  logic [NUM_REQUESTERS-1:0]      i_s_axis_tlast,
  output logic                           o_m_axis_tvalid,
  input  logic                           i_m_axis_tready,
  output logic [7:0]                     o_m_axis_tdata,
  output logic                           o_m_axis_tlast,
  output logic [NUM_REQUESTERS-1:0]      o_grant,
  output logic                           o_overlength,
  output logic                           o_watchdog_abort
);

  localparam int GW = $clog2(NUM_REQUESTERS);
  localparam logic [7:0] LAST_BEAT = 8'(MAX_PACKET_LENGTH_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
`ifdef UART_PACKET_ARB_WATCHDOG_EN
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
`endif

  // Reject unsupported parameter sets at elaboration.
  if (NUM_REQUESTERS < 2 || NUM_REQUESTERS > 8 ||
      MAX_PACKET_LENGTH_BYTES < 1 || MAX_PACKET_LENGTH_BYTES > 256 ||
      WATCHDOG_CYCLES < 1) begin : g_bad_cfg
    $error("uart_packet_arbiter: parameter out of range");
  end

  logic [1:0]                r_state;
  logic [GW-1:0]             r_gidx;
  logic [GW-1:0]             r_last;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic [7:0]                r_beats;
  logic                      r_overlength;

  logic [GW-1:0] w_pick;
  logic [GW-1:0] w_idx;
  logic          w_pick_vld;
  logic          w_src_vld;
  logic          w_src_last;
  logic          w_forced;
  logic          w_hs;

  // Pick the first requester after the previous owner, wrapping around.
  always_comb begin
    w_pick     = r_last;
    w_idx      = r_last;
    w_pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      w_idx = GW'((int'(r_last) + k) % NUM_REQUESTERS);
      if (!w_pick_vld && i_s_axis_tvalid[w_idx]) begin
        w_pick     = w_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  // Route the owner to the master port; everything is quiet otherwise.
  always_comb begin
    w_src_vld       = i_s_axis_tvalid[r_gidx];
    w_src_last      = i_s_axis_tlast[r_gidx];
    w_forced        = (r_beats == LAST_BEAT);
    o_s_axis_tready = '0;
    o_m_axis_tvalid = 1'b0;
    o_m_axis_tdata  = 8'h00;
    o_m_axis_tlast  = 1'b0;
    case (r_state)
      S_PASS: begin
        o_m_axis_tvalid         = w_src_vld;
        o_m_axis_tdata          = i_s_axis_tdata[r_gidx];
        o_m_axis_tlast          = w_src_last | w_forced;
        o_s_axis_tready[r_gidx] = i_m_axis_tready;
      end
`ifdef UART_PACKET_ARB_WATCHDOG_EN
      S_ABORT: begin
        o_m_axis_tvalid = 1'b1;
        o_m_axis_tlast  = 1'b1;
      end
`endif
      default: ;
    endcase
    w_hs = o_m_axis_tvalid & i_m_axis_tready;
  end

`ifdef UART_PACKET_ARB_WATCHDOG_EN
  logic [WW-1:0] r_wd;
  logic          r_wd_abort;
`endif

  // Grant, beat counting and packet termination.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_gidx       <= '0;
      r_last       <= GW'(NUM_REQUESTERS - 1);
      r_grant      <= '0;
      r_beats      <= 8'd0;
      r_overlength <= 1'b0;
`ifdef UART_PACKET_ARB_WATCHDOG_EN
      r_wd         <= '0;
      r_wd_abort   <= 1'b0;
`endif
    end else begin
      r_overlength <= 1'b0;
`ifdef UART_PACKET_ARB_WATCHDOG_EN
      r_wd_abort   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_PASS;
            r_gidx  <= w_pick;
            r_grant <= NUM_REQUESTERS'(1) << w_pick;
            r_beats <= 8'd0;
`ifdef UART_PACKET_ARB_WATCHDOG_EN
            r_wd    <= '0;
`endif
          end
        end
        S_PASS: begin
          if (w_hs) begin
            r_beats <= r_beats + 8'd1;
            if (o_m_axis_tlast) begin
              r_state      <= S_IDLE;
              r_last       <= r_gidx;
              r_grant      <= '0;
              r_overlength <= w_forced & ~w_src_last;
            end
          end
`ifdef UART_PACKET_ARB_WATCHDOG_EN
          if (w_src_vld) begin
            r_wd <= '0;
          end else if (r_wd == WD_LAST) begin
            r_state <= S_ABORT;
            r_wd    <= '0;
          end else begin
            r_wd <= r_wd + WW'(1);
          end
`endif
        end
`ifdef UART_PACKET_ARB_WATCHDOG_EN
        S_ABORT: begin
          if (i_m_axis_tready) begin
            r_state    <= S_IDLE;
            r_last     <= r_gidx;
            r_grant    <= '0;
            r_wd_abort <= 1'b1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_overlength = r_overlength;
`ifdef UART_PACKET_ARB_WATCHDOG_EN
  assign o_watchdog_abort = r_wd_abort;
`else
  assign o_watchdog_abort = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_arbiter.sv
// Directed scoreboard bench for uart_packet_arbiter.
// Watchdog case follows UART_PACKET_ARB_WATCHDOG_EN.
module tb_uart_packet_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]      s_tvalid = '0;
  logic [N-1:0]      s_tready;
  logic [N-1:0][7:0] s_tdata = '0;
  logic [N-1:0]      s_tlast = '0;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [7:0] m_tdata;
  logic       m_tlast;
  logic [N-1:0] grant;
  logic ovl;
  logic wda;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  uart_packet_arbiter #(
    .NUM_REQUESTERS(N),
    .MAX_PACKET_LENGTH_BYTES(16),
    .WATCHDOG_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_s_axis_tvalid(s_tvalid),
    .o_s_axis_tready(s_tready),
    .i_s_axis_tdata(s_tdata),
    .i_s_axis_tlast(s_tlast),
    .o_m_axis_tvalid(m_tvalid),
    .i_m_axis_tready(m_tready),
    .o_m_axis_tdata(m_tdata),
    .o_m_axis_tlast(m_tlast),
    .o_grant(grant),
    .o_overlength(ovl),
    .o_watchdog_abort(wda)
  );

  typedef struct {
    logic [1:0] src;
    logic [7:0] data;
    logic       last;
    logic       ov;
    logic       wd;
  } exp_t;

  exp_t sb[$];
  int   beat_cyc[$];
  logic [8:0] sq [N][64];
  int wp [N];
  int rp [N];
  logic [N-1:0] hs_snap = '0;
  logic pend_ovl = 1'b0;
  logic pend_wd = 1'b0;
  logic pend_idle = 1'b0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic prev_l = 1'b0;
  int stall_seen = 0;
  logic [N-1:0] oh;
  exp_t e;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input int s, input logic [7:0] d, input logic l);
    sq[s][wp[s]] = {l, d};
    wp[s]++;
  endtask

  task automatic exp_beat(input logic [1:0] s, input logic [7:0] d,
                          input logic l, input logic ov, input logic wd);
    exp_t x;
    x.src = s; x.data = d; x.last = l; x.ov = ov; x.wd = wd;
    sb.push_back(x);
  endtask

  task automatic push_pkt(input int s, input int base, input int len);
    for (int i = 0; i < len; i++)
      push_beat(s, 8'(base + i), (i == len - 1));
  endtask

  task automatic exp_pkt(input int s, input int base, input int len);
    for (int i = 0; i < len; i++)
      exp_beat(2'(s), 8'(base + i), (i == len - 1), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_tready", 32'(s_tready), 0);
    check("rst_mvalid", 32'(m_tvalid), 0);
    check("rst_mlast", 32'(m_tlast), 0);
    check("rst_mdata", 32'(m_tdata), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_ovl", 32'(ovl), 0);
    check("rst_wd", 32'(wda), 0);
    sb.delete();
    beat_cyc.delete();
    for (int s = 0; s < N; s++) begin
      rp[s] = 0;
      wp[s] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge clk);
      #1;
      n++;
      done = (sb.size() == 0);
      for (int s = 0; s < N; s++)
        if (rp[s] != wp[s]) done = 1'b0;
    end
    repeat (3) @(negedge clk);
    check({tag, "_drain"}, 32'(done), 1);
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string tag);
    int n;
    n = 0;
    while (grant !== g && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_grant"}, 32'(grant), 32'(g));
  endtask

  always @(posedge clk) cyc++;

  // Source models: present the head of each byte queue, pop on handshake.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < N; s++) begin
      if (rst_n && hs_snap[s] && rp[s] < wp[s]) rp[s]++;
      if (rp[s] < wp[s]) begin
        s_tvalid[s] = 1'b1;
        s_tdata[s]  = sq[s][rp[s]][7:0];
        s_tlast[s]  = sq[s][rp[s]][8];
      end else begin
        s_tvalid[s] = 1'b0;
        s_tdata[s]  = 8'h00;
        s_tlast[s]  = 1'b0;
      end
    end
    hs_snap = '0;
  end

  // Master-side monitor and scoreboard checker.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend_ovl   = 1'b0;
      pend_wd    = 1'b0;
      pend_idle  = 1'b0;
      prev_stall = 1'b0;
      hs_snap    = '0;
    end else begin
      check("ovl_pulse", 32'(ovl), 32'(pend_ovl));
      check("wd_pulse", 32'(wda), 32'(pend_wd));
      if (pend_idle) begin
        check("idle_grant", 32'(grant), 0);
        check("idle_mvalid", 32'(m_tvalid), 0);
      end
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 1);
        check("stall_data", 32'(m_tdata), 32'(prev_d));
        check("stall_last", 32'(m_tlast), 32'(prev_l));
        stall_seen++;
      end
      pend_ovl  = 1'b0;
      pend_wd   = 1'b0;
      pend_idle = 1'b0;
      hs_snap   = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        check("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          oh = '0;
          oh[e.src] = 1'b1;
          check("beat_data", 32'(m_tdata), 32'(e.data));
          check("beat_last", 32'(m_tlast), 32'(e.last));
          check("beat_grant", 32'(grant), 32'(oh));
          pend_ovl  = e.ov;
          pend_wd   = e.wd;
          pend_idle = e.last;
          beat_cyc.push_back(cyc);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d     = m_tdata;
      prev_l     = m_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    #2;
    do_reset();

    // Two simultaneous 3-byte packets: source 0 then source 2.
    push_pkt(0, 8'hA0, 3);
    push_pkt(2, 8'hC0, 3);
    exp_pkt(0, 8'hA0, 3);
    exp_pkt(2, 8'hC0, 3);
    wait_drain("t030");
    check("t030_beats", 32'(beat_cyc.size()), 6);
    if (beat_cyc.size() == 6)
      check("t030_gap", 32'(beat_cyc[3] - beat_cyc[2]), 2);

    // Everyone requesting single-byte packets: strict rotation.
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++)
        push_pkt(s, 16 * s + k, 1);
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < N; s++)
        exp_pkt(s, 16 * s + k, 1);
    wait_drain("t031");
    check("t031_beats", 32'(beat_cyc.size()), 8);
    for (int i = 1; i < beat_cyc.size(); i++)
      check("t031_gap", 32'(beat_cyc[i] - beat_cyc[i-1]), 2);

    // 20-byte packet gets split at 16 with a forced tlast.
    do_reset();
    push_pkt(1, 8'h40, 20);
    for (int i = 0; i < 20; i++)
      exp_beat(2'd1, 8'(8'h40 + i), (i == 15) || (i == 19),
               (i == 15), 1'b0);
    wait_drain("t032");
    check("t032_beats", 32'(beat_cyc.size()), 20);
    if (beat_cyc.size() == 20)
      check("t032_gap", 32'(beat_cyc[16] - beat_cyc[15]), 2);

    // Master back-pressure 1,0,0,1 during a 4-byte packet.
    do_reset();
    push_pkt(0, 8'h70, 4);
    exp_pkt(0, 8'h70, 4);
    s0 = stall_seen;
    wait_grant(4'b0001, "t033");
    @(posedge clk); #2; m_tready = 1'b0;
    @(posedge clk); #2; m_tready = 1'b0;
    @(posedge clk); #2; m_tready = 1'b1;
    wait_drain("t033");
    check("t033_stalls", 32'(stall_seen - s0), 2);
    check("t033_beats", 32'(beat_cyc.size()), 4);

    // Source 3 stalls after two bytes while source 0 waits.
    do_reset();
    push_beat(3, 8'h31, 1'b0);
    push_beat(3, 8'h32, 1'b0);
    exp_beat(2'd3, 8'h31, 1'b0, 1'b0, 1'b0);
    exp_beat(2'd3, 8'h32, 1'b0, 1'b0, 1'b0);
`ifdef UART_PACKET_ARB_WATCHDOG_EN
    exp_beat(2'd3, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_grant(4'b1000, "t034");
    push_pkt(0, 8'h50, 2);
    exp_pkt(0, 8'h50, 2);
    wait_drain("t034");
    check("t034_beats", 32'(beat_cyc.size()), 5);
    if (beat_cyc.size() == 5)
      check("t034_wd_gap", 32'(beat_cyc[2] - beat_cyc[1]), 9);
`else
    wait_grant(4'b1000, "t034");
    push_pkt(0, 8'h50, 2);
    repeat (20) @(negedge clk);
    #1;
    check("t034_hold_grant", 32'(grant), 32'h8);
    check("t034_hold_mvalid", 32'(m_tvalid), 0);
    check("t034_hold_tready", 32'(s_tready), 32'h8);
    check("t034_hold_sb", 32'(sb.size()), 0);
    push_beat(3, 8'h33, 1'b1);
    exp_beat(2'd3, 8'h33, 1'b1, 1'b0, 1'b0);
    exp_pkt(0, 8'h50, 2);
    wait_drain("t034");
    check("t034_beats", 32'(beat_cyc.size()), 5);
`endif

    // Reset on the second beat abandons the packet; source 0 wins after.
    do_reset();
    push_pkt(0, 8'h90, 4);
    exp_beat(2'd0, 8'h90, 1'b0, 1'b0, 1'b0);
    exp_beat(2'd0, 8'h91, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    check("t035_sb_at_beat2", 32'(sb.size()), 0);
    check("t035_beat2_live", 32'(m_tvalid && m_tready), 1);
    do_reset();
    push_pkt(1, 8'hB0, 2);
    push_pkt(0, 8'hE0, 2);
    exp_pkt(0, 8'hE0, 2);
    exp_pkt(1, 8'hB0, 2);
    wait_drain("t035");
    check("t035_beats", 32'(beat_cyc.size()), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
